// File: rtl/sobel_window_gen_pkg.sv
// Shared window definitions for the Sobel window producer and the Sobel filter.
// Tap i of a window sits at bits [i*DW +: DW], with i = 3*row + col.
package sobel_window_gen_pkg;

  localparam int TAP_TL   = 0;
  localparam int TAP_TC   = 1;
  localparam int TAP_TR   = 2;
  localparam int TAP_ML   = 3;
  localparam int TAP_MC   = 4;
  localparam int TAP_MR   = 5;
  localparam int TAP_BL   = 6;
  localparam int TAP_BC   = 7;
  localparam int TAP_BR   = 8;
  localparam int NUM_TAPS = 9;

  // Nine taps plus one spare top bit, which is always driven to 0.
  function automatic int win_width(input int dw);
    return NUM_TAPS * dw + 1;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line buffer with asynchronous read, so the old word at addr_i
// is visible in the same cycle that a new word is written there.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays get no reset; resetting them would turn the RAM into flops.
  always_ff @(posedge CLK) begin
    if (wr_en_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 neighbourhoods from a raster pixel stream using two line buffers
// (packed into one 2*DW-wide RAM) and a 3x3 shift register of taps.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_valid,
  input  logic [DW-1:0]            i_pixel,
  input  logic                     i_sof,
  output logic [win_width(DW)-1:0] o_window,
  output logic                     o_valid,
  output logic                     o_eol,
  output logic                     o_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          last_col, last_row;

  logic [2*DW-1:0] lb_rdata, lb_wdata;
  logic [DW-1:0]   lb0_rd, lb1_rd;

  logic [DW-1:0] win_q [NUM_TAPS];
  logic [DW-1:0] win_d [NUM_TAPS];
  logic          valid_q, valid_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;

  // A start-of-frame pixel is placed at (0,0) no matter where the counters are.
  always_comb begin
    cur_col  = i_sof ? '0 : col_q;
    cur_row  = i_sof ? '0 : row_q;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (i_valid) begin
      col_d = last_col ? '0 : cur_col + 1'b1;
      row_d = cur_row;
      if (last_col) row_d = last_row ? '0 : cur_row + 1'b1;
    end
  end

  // Upper half holds the line two above (lb1), lower half the previous line (lb0).
  assign lb1_rd   = lb_rdata[2*DW-1:DW];
  assign lb0_rd   = lb_rdata[DW-1:0];
  assign lb_wdata = {lb0_rd, i_pixel};

  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * DW)
  ) u_line_buf (
    .CLK     (CLK),
    .wr_en_i (i_valid),
    .addr_i  (cur_col),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) win_d[i] = win_q[i];
    if (i_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[TAP_TR] = lb1_rd;
      win_d[TAP_MR] = lb0_rd;
      win_d[TAP_BR] = i_pixel;
    end
  end

  // Border rows and columns never yield a window, which also hides stale line data.
  assign valid_d = i_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign eol_d   = valid_d && last_col;
  assign eof_d   = eol_d && last_row;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) win_q[i] <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      for (int i = 0; i < NUM_TAPS; i++) win_q[i] <= win_d[i];
    end
  end

  always_comb begin
    o_window = '0;
    for (int i = 0; i < NUM_TAPS; i++) o_window[i*DW +: DW] = win_q[i];
  end

  assign o_valid = valid_q;
  assign o_eol   = eol_q;
  assign o_eof   = eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized bench for sobel_window_gen on a 5x4 image; expected windows come
// from a frame-image array indexed by (row, col) of the current frame.
module tb_sobel_window_gen;

  localparam int DW    = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int WW    = 9 * DW + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_pixel = '0;
  logic          i_sof = 1'b0;
  logic [WW-1:0] o_window;
  logic          o_valid, o_eol, o_eof;

  sobel_window_gen #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .i_valid  (i_valid),
    .i_pixel  (i_pixel),
    .i_sof    (i_sof),
    .o_window (o_window),
    .o_valid  (o_valid),
    .o_eol    (o_eol),
    .o_eof    (o_eof)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: pixels of the current frame at their raster position.
  logic [DW-1:0] img [IMG_H][IMG_W];
  int            mr = 0;
  int            mc = 0;

  int            pulses = 0;
  int            eol_seen = 0;
  int            eof_seen = 0;
  logic [WW-1:0] win_log [$];

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] pix, input logic sof);
    logic          ev, eeol, eeof;
    logic [WW-1:0] ew;
    @(negedge CLK);
    i_valid = v;
    i_pixel = pix;
    i_sof   = sof;
    ev = 1'b0; eeol = 1'b0; eeof = 1'b0; ew = '0;
    if (v) begin
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
        ev = 1'b1;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            ew[(3*rr + cc)*DW +: DW] = img[mr-2+rr][mc-2+cc];
        eeol = (mc == IMG_W - 1);
        eeof = eeol && (mr == IMG_H - 1);
      end
      mc++;
      if (mc == IMG_W) begin
        mc = 0;
        mr = (mr == IMG_H - 1) ? 0 : mr + 1;
      end
    end
    @(posedge CLK);
    #1;
    check("valid", WW'(o_valid), WW'(ev));
    if (o_valid) begin
      pulses++;
      if (o_eol) eol_seen++;
      if (o_eof) eof_seen++;
      win_log.push_back(o_window);
    end
    if (ev) begin
      check("window", o_window, ew);
      check("eol", WW'(o_eol), WW'(eeol));
      check("eof", WW'(o_eof), WW'(eeof));
    end else begin
      check("idle_flags", WW'({o_eol, o_eof}), WW'(0));
    end
  endtask

  task automatic send(input logic [DW-1:0] pix, input logic sof, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, pix, sof);
  endtask

  task automatic frame(input bit gaps, input bit sof, input bit rnd, input logic [DW-1:0] base);
    logic [DW-1:0] pix;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        pix = rnd ? DW'($urandom) : base + DW'(16*r + c);
        send(pix, sof && r == 0 && c == 0, gaps);
      end
  endtask

  // Rows 0 and 1 plus row 2 up to column 2, ending on the first window of a frame.
  task automatic partial_to_22(input logic sof);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < IMG_W; c++)
        if (r < 2 || c <= 2) send(DW'(16*r + c), sof && r == 0 && c == 0, 1'b0);
  endtask

  initial begin
    int            p0, e0, f0, n0;
    logic [WW-1:0] first_exp;
    logic [WW-1:0] pre_sof_exp;

    first_exp = {1'b0, 8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", WW'(o_valid), WW'(0));
    check("rst_window", o_window, WW'(0));
    check("rst_flags", WW'({o_eol, o_eof}), WW'(0));
    @(negedge CLK);
    RST = 1'b1;

    // Continuous frame straight after reset, no i_sof
    p0 = pulses; e0 = eol_seen; f0 = eof_seen; n0 = win_log.size();
    frame(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0);
    check("t1_pulses", WW'(pulses - p0), WW'(6));
    check("t1_eols", WW'(eol_seen - e0), WW'(2));
    check("t1_eofs", WW'(eof_seen - f0), WW'(1));
    check("t1_first_win", win_log[n0], first_exp);

    // Same frame with random gaps: identical window sequence
    p0 = pulses;
    frame(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    check("t2_pulses", WW'(pulses - p0), WW'(6));
    for (int i = 0; i < 6; i++) check("t2_same_seq", win_log[n0 + 6 + i], win_log[n0 + i]);

    // Two back-to-back frames, only the first carrying i_sof
    p0 = pulses; n0 = win_log.size();
    frame(1'b0, 1'b1, 1'b0, 8'h00);
    frame(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0);
    check("t3_pulses", WW'(pulses - p0), WW'(12));
    check("t3_frame2_first", win_log[n0 + 6], win_log[n0]);

    // Abort with i_sof at (2,3), then a full frame of distinct pixel values
    n0 = win_log.size();
    partial_to_22(1'b1);
    pre_sof_exp = first_exp;
    check("t4_last_pre_sof", win_log[win_log.size() - 1], pre_sof_exp);
    p0 = pulses; n0 = win_log.size();
    frame(1'b0, 1'b1, 1'b0, 8'h80);
    cycle(1'b0, 8'h00, 1'b0);
    check("t4_pulses", WW'(pulses - p0), WW'(6));
    check("t4_first_new", win_log[n0],
          {1'b0, 8'ha2, 8'ha1, 8'ha0, 8'h92, 8'h91, 8'h90, 8'h82, 8'h81, 8'h80});

    // One-cycle reset in row 2, just after a window pulse
    partial_to_22(1'b1);
    @(negedge CLK);
    i_valid = 1'b0;
    RST = 1'b0;
    #1;
    check("t5_rst_valid", WW'(o_valid), WW'(0));
    check("t5_rst_window", o_window, WW'(0));
    @(negedge CLK);
    RST = 1'b1;
    mr = 0;
    mc = 0;
    p0 = pulses;
    frame(1'b0, 1'b0, 1'b0, 8'h40);
    cycle(1'b0, 8'h00, 1'b0);
    check("t5_pulses", WW'(pulses - p0), WW'(6));

    // Random pixels, random gaps and occasional mid-frame i_sof
    for (int n = 0; n < 300; n++)
      send(DW'($urandom), ($urandom_range(0, 39) == 0), 1'b1);
    for (int k = 0; k < 3; k++) frame(1'b1, 1'b0, 1'b1, 8'h00);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
